// File: rtl/module_rr_arbiter.sv
// Round-robin arbiter from the per-module singles/timetag FIFOs to the ethernet TX FIFO.
// Define BURST_LIMIT_EN to let a source keep the grant for up to BURST consecutive words.
module module_rr_arbiter #(
    parameter int  NMODULES = 4,
    parameter int  LENGTH   = 128,
    parameter int  BURST    = 16,
    localparam int SRC_W    = (NMODULES > 1) ? $clog2(NMODULES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NMODULES-1:0]        in_valid,
    output logic [NMODULES-1:0]        in_ready,
    input  logic [NMODULES*LENGTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LENGTH-1:0]          out_data,
    output logic [SRC_W-1:0]           out_src,
    output logic                       grant_err
);

    localparam int unsigned NMOD_U = NMODULES;

    if (BURST < 1 || BURST > 255) begin : g_burst_range
        $error("module_rr_arbiter: BURST must be in 1..255");
    end

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NMOD_U) s = s - NMOD_U;
        return SRC_W'(s);
    endfunction

    // First valid source scanning cyclically from ptr; MSB flags that one exists.
    function automatic logic [SRC_W:0] pick(input logic [NMODULES-1:0] v, input logic [SRC_W-1:0] ptr);
        logic [SRC_W:0]   r;
        logic [SRC_W-1:0] idx;
        r = '0;
        for (int k = NMODULES - 1; k >= 0; k--) begin
            idx = wrap_inc(ptr, 32'(k));
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  cand;
    logic              cand_found;
    logic [LENGTH-1:0] cand_data;
    logic              can_accept;
    logic              lock_ok;
    logic              xfer;
    logic              pop;
    logic              mon_err;

    logic [1:0]        buf_cnt;
    logic              buf_wr;
    logic              buf_rd;
    logic [LENGTH-1:0] buf_data [2];
    logic [SRC_W-1:0]  buf_src  [2];

`ifdef BURST_LIMIT_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0] state;
    logic [7:0] burst_cnt;

    assign lock_ok = (state != ST_LOCK) || (cand == rr_ptr);
`else
    assign lock_ok = 1'b1;
`endif

    always_comb begin
        {cand_found, cand} = pick(in_valid, rr_ptr);
    end

    always_comb begin
        cand_data = '0;
        for (int i = 0; i < NMODULES; i++) begin
            if (cand == SRC_W'(i)) cand_data = in_data[i*LENGTH +: LENGTH];
        end
    end

    // Accept decision uses only registered occupancy, never out_ready.
    assign can_accept = (buf_cnt < 2'd2);

    always_comb begin
        in_ready = '0;
        if (rst && can_accept && cand_found && lock_ok) in_ready[cand] = 1'b1;
    end

    assign xfer    = |(in_ready & in_valid);
    assign pop     = out_valid & out_ready;
    assign mon_err = (|(in_ready & ~in_valid)) | ((|(in_ready & in_valid)) & ~xfer);

    // Output buffer: two {src, data} entries, head presented on the outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_cnt <= 2'd0;
            buf_wr  <= 1'b0;
            buf_rd  <= 1'b0;
        end else begin
            if (xfer) buf_wr <= ~buf_wr;
            if (pop)  buf_rd <= ~buf_rd;
            case ({xfer, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            buf_data[buf_wr] <= cand_data;
            buf_src[buf_wr]  <= cand;
        end
    end

    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = out_valid ? buf_data[buf_rd] : '0;
    assign out_src   = out_valid ? buf_src[buf_rd]  : '0;

    // Grant pointer and burst lock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
`ifdef BURST_LIMIT_EN
            state     <= ST_IDLE;
            burst_cnt <= 8'd0;
`endif
        end else begin
`ifdef BURST_LIMIT_EN
            if (state == ST_IDLE) begin
                if (xfer) begin
                    if (BURST > 1) begin
                        state     <= ST_LOCK;
                        rr_ptr    <= cand;
                        burst_cnt <= 8'd1;
                    end else begin
                        rr_ptr <= wrap_inc(cand, 32'd1);
                    end
                end
            end else begin
                if (xfer) begin
                    if (burst_cnt == 8'(BURST - 1)) begin
                        state     <= ST_IDLE;
                        rr_ptr    <= wrap_inc(cand, 32'd1);
                        burst_cnt <= 8'd0;
                    end else begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end else if (can_accept && !in_valid[rr_ptr]) begin
                    state     <= ST_IDLE;
                    rr_ptr    <= wrap_inc(rr_ptr, 32'd1);
                    burst_cnt <= 8'd0;
                end
            end
`else
            if (xfer) rr_ptr <= wrap_inc(cand, 32'd1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)         grant_err <= 1'b0;
        else if (mon_err) grant_err <= 1'b1;
    end

endmodule

// File: tb/tb_module_rr_arbiter.sv
// Bench for module_rr_arbiter: queue-based reference model checked every cycle plus directed literals.
// Burst expectations follow BURST_LIMIT_EN when it is defined for the build.
module tb_module_rr_arbiter;

    localparam int N = 4;
    localparam int L = 128;
    localparam int B = 4;
`ifdef BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic           clk_100 = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*L-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [L-1:0]   out_data;
    logic [1:0]     out_src;
    logic           grant_err;

    int checks = 0;
    int errors = 0;

    int unsigned popped [N] = '{default: 0};
    int unsigned limit  [N];

    typedef struct {
        logic [1:0]   src;
        logic [L-1:0] data;
    } ent_t;

    ent_t mq[$];
    ent_t log_q[$];

    int m_ptr    = 0;
    int m_owner  = 0;
    int m_run    = 0;
    bit m_locked = 1'b0;

    int exp_rr  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_b4  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int exp_a4  [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    int exp_e_b [4] = '{3, 3, 1, 1};
    int exp_e_a [4] = '{3, 1, 3, 1};

    module_rr_arbiter #(.NMODULES(N), .LENGTH(L), .BURST(B)) dut (
        .clk       (clk_100),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .grant_err (grant_err)
    );

    always #5 clk_100 = ~clk_100;

    function automatic logic [L-1:0] word(input int i, input int unsigned c);
        return {96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 16'(i), 16'(c)};
    endfunction

    // Upstream FIFOs: module i holds words until popped reaches limit.
    always_comb begin
        in_valid = '0;
        in_data  = '0;
        for (int i = 0; i < N; i++) begin
            in_valid[i]          = popped[i] < limit[i];
            in_data[i*L +: L]    = word(i, popped[i]);
        end
    end

    always @(posedge clk_100) begin
        for (int i = 0; i < N; i++)
            if (in_ready[i] && in_valid[i]) popped[i] <= popped[i] + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compare at negedge, then advance as the next posedge will.
    initial begin : model
        int       cand;
        int       idx;
        logic [N-1:0] exp_rdy;
        @(posedge clk_100);
        forever begin
            @(negedge clk_100);
            cand = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (cand < 0 && in_valid[idx]) cand = idx;
            end
            exp_rdy = '0;
            if (rst && mq.size() < 2 && cand >= 0 && (!m_locked || cand == m_owner))
                exp_rdy[cand] = 1'b1;

            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("out_src", out_src, mq[0].src);
                chk("out_data", out_data, mq[0].data);
            end
            chk("in_ready", in_ready, exp_rdy);
            chk("grant_err", grant_err, 1'b0);
            if (out_valid && out_ready) log_q.push_back('{out_src, out_data});

            if (!rst) begin
                mq.delete();
                m_ptr = 0; m_owner = 0; m_run = 0; m_locked = 1'b0;
            end else begin
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                if (exp_rdy != '0) begin
                    mq.push_back('{cand[1:0], word(cand, popped[cand])});
                    if (m_locked) begin
                        m_run++;
                        if (m_run == B) begin
                            m_locked = 1'b0; m_run = 0; m_ptr = (cand + 1) % N;
                        end
                    end else if (BURST_EN && B > 1) begin
                        m_locked = 1'b1; m_owner = cand; m_run = 1; m_ptr = cand;
                    end else begin
                        m_ptr = (cand + 1) % N;
                    end
                end else if (m_locked && mq.size() < 2 && !in_valid[m_owner]) begin
                    m_locked = 1'b0; m_run = 0; m_ptr = (m_owner + 1) % N;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    task automatic set_lim(input logic [N-1:0] mask, input int unsigned n);
        for (int i = 0; i < N; i++) limit[i] = mask[i] ? popped[i] + n : popped[i];
    endtask

    initial begin : stim
        int unsigned base;
        logic [L-1:0] held;
        rst       = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) limit[i] = 1000;

        // Reset held with every input valid.
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_in_ready", in_ready, 4'b0000);
            chk("rst_out_src", out_src, 2'd0);
            chk("rst_grant_err", grant_err, 1'b0);
        end

        // Fairness with all four valid.
        rst = 1'b1;
        out_ready = 1'b1;
        log_q.delete();
        step(9);
        chk("rr_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < log_q.size()) chk($sformatf("rr_src%0d", i), log_q[i].src, exp_rr[i]);
        if (log_q.size() > 0) chk("rr_first_data", log_q[0].data, word(0, 0));

        // Backpressure on a single source.
        set_lim(4'b0000, 0);
        step(3);
        base = popped[2];
        set_lim(4'b0100, 100);
        out_ready = 1'b0;
        step(1);
        held = out_data;
        chk("bp_first_word", held, word(2, base));
        step(4);
        chk("bp_accepted", popped[2] - base, 2);
        chk("bp_in_ready", in_ready, 4'b0000);
        chk("bp_stable", out_data, held);
        set_lim(4'b0000, 0);
        out_ready = 1'b1;
        log_q.delete();
        step(3);
        chk("bp_drain_count", log_q.size(), 2);
        if (log_q.size() > 1) begin
            chk("bp_drain0", log_q[0].data, word(2, base));
            chk("bp_drain1", log_q[1].data, word(2, base + 1));
        end

        // Modules 0 and 1 always valid from pointer 0.
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        set_lim(4'b0011, 1000);
        log_q.delete();
        step(10);
        chk("burst_count", log_q.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < log_q.size())
                chk($sformatf("burst_src%0d", i), log_q[i].src, BURST_EN ? exp_b4[i] : exp_a4[i]);

        // Module 3 offers two words, then module 1 joins.
        set_lim(4'b0000, 0);
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        log_q.delete();
        set_lim(4'b1000, 2);
        step(1);
        limit[1] = popped[1] + 1000;
        step(6);
        chk("early_count", log_q.size(), BURST_EN ? 5 : 6);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size())
                chk($sformatf("early_src%0d", i), log_q[i].src, BURST_EN ? exp_e_b[i] : exp_e_a[i]);

        // Reset with a full buffer.
        set_lim(4'b1111, 1000);
        out_ready = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        chk("midrst_out_valid", out_valid, 1'b0);
        set_lim(4'b1010, 100);
        step(1);
        rst = 1'b1;
        out_ready = 1'b1;
        log_q.delete();
        #1;
        chk("midrst_grant", in_ready, 4'b0010);
        step(2);
        if (log_q.size() > 0) chk("midrst_first_src", log_q[0].src, 2'd1);
        else chk("midrst_first_src_present", log_q.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
